// File: rtl/glom_packer.sv
// glom_packer: slices one input word through a descriptor table and packs the enabled fields, right-aligned, into out_data.
// Optional build macro GLOM_SIGN_EXTEND_EN sign-extends the packed result above out_len; the default is zero extension.
module glom_packer #(
  parameter  int DATA_W     = 32,
  parameter  int NUM_FIELDS = 4,
  parameter  int OUT_W      = 32,
  localparam int IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1,
  localparam int LEN_W      = $clog2(OUT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [BIT_W-1:0]  cfg_msb,
  input  logic [BIT_W-1:0]  cfg_lsb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_ovf,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload hold until that edge, and ready never depends on valid.

  typedef enum logic [1:0] {IDLE = 2'd0, GATHER = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic              en_q  [NUM_FIELDS];
  logic [BIT_W-1:0]  msb_q [NUM_FIELDS];
  logic [BIT_W-1:0]  lsb_q [NUM_FIELDS];

  logic [DATA_W-1:0] data_q;
  logic [OUT_W-1:0]  acc_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovf_q;
  logic [IDX_W-1:0]  idx_q;

  logic              cur_en;
  logic [BIT_W-1:0]  cur_msb, cur_lsb;
  logic              fld_ok, fld_fits, fld_take, fld_drop;
  logic [BIT_W:0]    fld_w;
  logic [DATA_W-1:0] fld_bits;
  logic [OUT_W-1:0]  acc_nxt;
  logic              last_idx;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign last_idx = (idx_q == IDX_W'(NUM_FIELDS - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = GATHER;
      GATHER:  if (last_idx)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Field extraction for the descriptor at the current index
  always_comb begin
    cur_en   = en_q[idx_q];
    cur_msb  = msb_q[idx_q];
    cur_lsb  = lsb_q[idx_q];
    fld_ok   = cur_en && (cur_msb >= cur_lsb);
    fld_w    = {1'b0, cur_msb} - {1'b0, cur_lsb} + (BIT_W+1)'(1);
    fld_fits = (32'(len_q) + 32'(fld_w)) <= 32'(OUT_W);
    fld_take = (state_q == GATHER) && fld_ok && fld_fits;
    fld_drop = (state_q == GATHER) && fld_ok && !fld_fits;
    fld_bits = (data_q >> cur_lsb) & ({DATA_W{1'b1}} >> ((BIT_W+1)'(DATA_W) - fld_w));
    acc_nxt  = (acc_q << fld_w) | OUT_W'(fld_bits);
  end

  // Datapath and descriptor table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      acc_q  <= '0;
      len_q  <= '0;
      ovf_q  <= 1'b0;
      idx_q  <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        en_q[i]  <= 1'b0;
        msb_q[i] <= '0;
        lsb_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && cfg_we && int'(cfg_idx) < NUM_FIELDS) begin
        en_q[cfg_idx]  <= cfg_en;
        msb_q[cfg_idx] <= cfg_msb;
        lsb_q[cfg_idx] <= cfg_lsb;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            acc_q  <= '0;
            len_q  <= '0;
            ovf_q  <= 1'b0;
            idx_q  <= '0;
          end
        end
        GATHER: begin
          if (fld_take) begin
            acc_q <= acc_nxt;
            len_q <= len_q + LEN_W'(fld_w);
          end else if (fld_drop) begin
            ovf_q <= 1'b1;
          end
          idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef GLOM_SIGN_EXTEND_EN
  logic [OUT_W-1:0] hi_mask;
  logic [OUT_W-1:0] sign_sh;
`endif

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    out_len   = len_q;
    out_ovf   = ovf_q;
    dbg_state = state_q;
    out_data  = acc_q;
`ifdef GLOM_SIGN_EXTEND_EN
    hi_mask = {OUT_W{1'b1}} << len_q;
    sign_sh = acc_q >> (len_q - LEN_W'(1));
    if (state_q == DONE && len_q != '0 && sign_sh[0])
      out_data = acc_q | hi_mask;
`endif
  end

endmodule

// File: doc/glom_packer.md
GLOM_PACKER -- requirements
Module: glom_packer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, input word width in bits.
REQ-002 The block SHALL have parameter NUM_FIELDS, default 4, number of field descriptors (range 1 to 16).
REQ-003 The block SHALL have parameter OUT_W, default 32, packed output width in bits (range 1 to 64).
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port reset  input  1  asynchronous, active-low reset; low asserts.
REQ-006 Port in_valid  input  1  input word offered.
REQ-007 Port in_ready  output  1  block accepts an input word.
REQ-008 Port in_data  input  DATA_W  word to slice.
REQ-009 Port cfg_we  input  1  descriptor write strobe.
REQ-010 Port cfg_idx  input  clog2(NUM_FIELDS) (minimum 1)  descriptor index.
REQ-011 Port cfg_en, cfg_msb, cfg_lsb  input  1 / clog2(DATA_W) / clog2(DATA_W)  descriptor enable and bit bounds.
REQ-012 Port out_valid  output  1  packed result available.
REQ-013 Port out_ready  input  1  consumer takes the result.
REQ-014 Port out_data  output  OUT_W  packed result, right-aligned.
REQ-015 Port out_len  output  clog2(OUT_W+1)  number of valid packed bits.
REQ-016 Port out_ovf  output  1  at least one enabled field was dropped for lack of room.
REQ-017 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 A descriptor table SHALL hold NUM_FIELDS entries {en, msb, lsb}; a cfg_we write SHALL take effect on the edge only in IDLE and SHALL be ignored in any other state.
REQ-019 The FSM SHALL have three states, IDLE, GATHER and DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 On an IDLE edge with in_valid=1, the FSM SHALL capture in_data, clear the accumulator, out_len, out_ovf and the field index, and enter GATHER.
REQ-021 GATHER SHALL process exactly one descriptor per cycle, in index order 0 to NUM_FIELDS-1; field 0 SHALL end up most significant, giving concatenation order.
REQ-022 For an enabled descriptor with msb >= lsb and w = msb-lsb+1: if out_len+w <= OUT_W, then acc <= (acc << w) | data[msb:lsb] and out_len += w; otherwise the field SHALL be dropped and out_ovf set to 1.
REQ-023 A disabled descriptor, or one with msb < lsb, SHALL be skipped with no change to acc, out_len or out_ovf.
REQ-024 After the last index, the FSM SHALL enter DONE; out_valid SHALL rise exactly NUM_FIELDS edges after the accepting edge.
REQ-025 In DONE, out_valid SHALL be 1 and out_data, out_len and out_ovf SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE with out_valid=0.
REQ-026 If every descriptor is disabled, the result SHALL be out_data=0, out_len=0, out_ovf=0, with the same latency.
REQ-027 Bits of out_data above out_len SHALL be zero unless REQ-032 applies.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, in_ready=1 (after the state changes), out_valid=0, out_data=0, out_len=0, out_ovf=0 and busy=0.
REQ-029 Reset SHALL clear all descriptors to en=0, msb=0, lsb=0.
REQ-030 Reset asserted during GATHER or DONE SHALL abandon the transaction; no out_valid pulse SHALL follow after release.

Configuration
REQ-031 Macro GLOM_SIGN_EXTEND_EN SHALL select the extension of the result above out_len.
REQ-032 With GLOM_SIGN_EXTEND_EN defined, bits of out_data at positions out_len and above SHALL replicate bit out_len-1 in DONE; if out_len=0, out_data SHALL be 0.
REQ-033 Without GLOM_SIGN_EXTEND_EN, the block SHALL zero-extend, and no sign logic SHALL be synthesised.

Verification
REQ-034 Defaults; f0={en,31,28}, f1={en,3,0}, others off; in_data=0x12345678 -> out_data=0x00000018, out_len=8, out_ovf=0, out_valid 4 edges after accept.
REQ-035 f0={en,31,28} only; in_data=0xF0000000 -> out_len=4; out_data=0x0000000F without the macro, 0xFFFFFFFF with GLOM_SIGN_EXTEND_EN.
REQ-036 All four descriptors={en,31,20}; in_data=0xABC00000 -> out_data=0x00ABCABC, out_len=24, out_ovf=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_data/out_len stable, in_ready=0, a cfg_we write is ignored (verified by readback on the next transaction).
REQ-038 reset pulsed low during GATHER index 2 -> outputs zero immediately, descriptors cleared, no out_valid after release; next word 0x12345678 with no config -> out_data=0, out_len=0.
